// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if - CP0 exception interface between the exception controller
// (master) and CP0 (slave).
//
// Signals (named from the controller's point of view):
//   int_sync_o       6   synchronised interrupt lines, to CP0 int_i
//   excepttype_o     32  exception code to CP0, 0 = none
//   exc_pc_o         32  faulting PC, to CP0 current_inst_addr_i
//   exc_delayslot_o  1   faulting instruction sits in a delay slot
//   cp0_status_i     32  CP0 Status read-back
//   cp0_cause_i      32  CP0 Cause read-back
//   cp0_epc_i        32  CP0 EPC read-back
interface exc_ctrl_if;
    logic [5:0]  int_sync_o;
    logic [31:0] excepttype_o;
    logic [31:0] exc_pc_o;
    logic        exc_delayslot_o;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;

    modport master (
        output int_sync_o,
        output excepttype_o,
        output exc_pc_o,
        output exc_delayslot_o,
        input  cp0_status_i,
        input  cp0_cause_i,
        input  cp0_epc_i
    );

    modport slave (
        input  int_sync_o,
        input  excepttype_o,
        input  exc_pc_o,
        input  exc_delayslot_o,
        output cp0_status_i,
        output cp0_cause_i,
        output cp0_epc_i
    );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl - initiator side of the CP0 exception interface.
//
// Samples the MEM-stage exception flags, synchronises the external interrupt
// lines and checks pending interrupts against Status/Cause (with bypass of a
// CP0 write still in write-back). A detected exception is issued to CP0 as a
// one-cycle registered command together with a pipeline flush and redirect
// PC; a hold-off period afterwards keeps flushed instructions from raising a
// second exception.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   int_i               raw asynchronous hardware interrupt lines
//   mem_valid_i         MEM holds a real instruction
//   mem_stall_i         MEM stalled this cycle
//   mem_exc_flags_i     {eret, overflow, trap, invalid, syscall}
//   mem_pc_i            PC of the MEM instruction
//   mem_delayslot_i     MEM instruction is in a delay slot
//   cp0                 CP0 exception interface (master side)
//   wb_cp0_we_i/_waddr_i/_data_i   CP0 write in write-back, for bypass
//   flush_o             flush all pipeline registers
//   new_pc_o            redirect target, valid while flush_o=1
//   busy_o              take or hold-off in progress
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
    parameter int          HOLDOFF    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       int_i,
    input  logic             mem_valid_i,
    input  logic             mem_stall_i,
    input  logic [4:0]       mem_exc_flags_i,
    input  logic [31:0]      mem_pc_i,
    input  logic             mem_delayslot_i,
    exc_ctrl_if.master       cp0,
    input  logic             wb_cp0_we_i,
    input  logic [4:0]       wb_cp0_waddr_i,
    input  logic [31:0]      wb_cp0_data_i,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic             busy_o
);

    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;
    localparam logic [3:0] CODE_ERET  = 4'he;
    localparam logic [3:0] HOLD_LOAD  = 4'(HOLDOFF - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_TAKE, ST_DRAIN} state_t;

    state_t      state;
    logic [3:0]  hold_cnt;
    logic [5:0]  int_meta_p0;
    logic [5:0]  int_sync_p1;

    logic [31:0] status_eff;
    logic [31:0] cause_eff;
    logic [31:0] epc_eff;
    logic        int_pending;
    logic [3:0]  cand_code;
    logic        take;
    logic        unused_bits;

    // Priority encoder: interrupt first, then syscall, invalid, trap,
    // overflow, eret. 0 means no candidate.
    function automatic logic [3:0] exc_code(input logic irq, input logic [4:0] flags);
        logic [3:0] code;
        code = 4'h0;
        if (irq)           code = 4'h1;
        else if (flags[0]) code = 4'h8;
        else if (flags[1]) code = 4'ha;
        else if (flags[2]) code = 4'hd;
        else if (flags[3]) code = 4'hc;
        else if (flags[4]) code = CODE_ERET;
        return code;
    endfunction

    // Stage p0/p1: two-flop interrupt synchroniser
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_meta_p0 <= '0;
            int_sync_p1 <= '0;
        end else begin
            int_meta_p0 <= int_i;
            int_sync_p1 <= int_meta_p0;
        end
    end

    assign cp0.int_sync_o = int_sync_p1;

    // A CP0 write still in write-back must be seen here, otherwise an ERET
    // or an mtc0 to Status/Cause would be evaluated against stale values.
    // Only the software interrupt bits of Cause are writable.
    always_comb begin
        status_eff = cp0.cp0_status_i;
        cause_eff  = cp0.cp0_cause_i;
        epc_eff    = cp0.cp0_epc_i;
        if (wb_cp0_we_i) begin
            if (wb_cp0_waddr_i == REG_STATUS) status_eff = wb_cp0_data_i;
            if (wb_cp0_waddr_i == REG_EPC)    epc_eff    = wb_cp0_data_i;
            if (wb_cp0_waddr_i == REG_CAUSE)  cause_eff[9:8] = wb_cp0_data_i[9:8];
        end
    end

    assign int_pending = (|(cause_eff[15:8] & status_eff[15:8]))
                         && status_eff[0] && !status_eff[1];

    // Bubbles never take anything, interrupts included, so EPC can never
    // be captured from an empty slot.
    assign cand_code = exc_code(int_pending, mem_exc_flags_i);
    assign take      = (state == ST_IDLE) && mem_valid_i && !mem_stall_i
                       && (cand_code != 4'h0);

    assign unused_bits = ^{status_eff[31:16], status_eff[7:2],
                           cause_eff[31:16], cause_eff[7:0]};

    // Stage p2: registered exception command and hold-off FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= ST_IDLE;
            hold_cnt            <= '0;
            cp0.excepttype_o    <= '0;
            cp0.exc_pc_o        <= '0;
            cp0.exc_delayslot_o <= 1'b0;
            flush_o             <= 1'b0;
            new_pc_o            <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        cp0.excepttype_o    <= {28'd0, cand_code};
                        cp0.exc_pc_o        <= mem_pc_i;
                        cp0.exc_delayslot_o <= mem_delayslot_i;
                        flush_o             <= 1'b1;
                        new_pc_o            <= (cand_code == CODE_ERET) ? epc_eff : EXC_VECTOR;
                        state               <= ST_TAKE;
                    end
                end
                ST_TAKE: begin
                    cp0.excepttype_o    <= '0;
                    cp0.exc_pc_o        <= '0;
                    cp0.exc_delayslot_o <= 1'b0;
                    flush_o             <= 1'b0;
                    new_pc_o            <= '0;
                    hold_cnt            <= HOLD_LOAD;
                    state               <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Candidates seen here are dropped, not queued.
                    if (hold_cnt == 4'd0) state <= ST_IDLE;
                    else                  hold_cnt <= hold_cnt - 4'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = (state != ST_IDLE);

endmodule
